// File: rtl/line_event_arbiter.sv
// line_event_arbiter
// Turns a synchronized multi-line bus into an ordered stream of timestamped
// edge events. Each line has a glitch filter and a one-deep pending slot. A
// round-robin arbiter shares one valid/ready event port among all lines.
//
// Ports:
//   sys_clk        system clock, rising edge
//   n_rst          asynchronous active-low reset
//   in_line        synchronized line levels
//   enable         1 = capture new events, 0 = filters track only
//   clr_overflow   single-cycle pulse clearing all overflow bits
//   filt_line      filtered line levels
//   out_valid      event available
//   out_ready      consumer accepts when out_valid & out_ready
//   out_index      line that produced the event
//   out_level      new filtered level (1 = rising, 0 = falling)
//   out_timestamp  timestamp of the qualifying edge
//   overflow       sticky per-line dropped-event flags
module line_event_arbiter #(
  parameter int                 WIDTH       = 4,
  parameter int                 FILTER_LEN  = 3,
  parameter int                 TS_WIDTH    = 16,
  parameter logic [WIDTH-1:0]   RESET_LEVEL = {WIDTH{1'b1}},
  parameter int                 IDX_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                sys_clk,
  input  logic                n_rst,
  input  logic [WIDTH-1:0]    in_line,
  input  logic                enable,
  input  logic                clr_overflow,
  output logic [WIDTH-1:0]    filt_line,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_index,
  output logic                out_level,
  output logic [TS_WIDTH-1:0] out_timestamp,
  output logic [WIDTH-1:0]    overflow
);

  localparam int              CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  logic [TS_WIDTH-1:0] ts_r;
  logic [CNT_W-1:0]    cnt_r      [WIDTH];
  logic [WIDTH-1:0]    pending_r;
  logic [WIDTH-1:0]    pend_level_r;
  logic [TS_WIDTH-1:0] pend_ts_r  [WIDTH];
  logic [IDX_W-1:0]    last_grant_r;

  logic [WIDTH-1:0]    qual_s;
  logic [WIDTH-1:0]    grant_vec_s;
  logic [WIDTH-1:0]    capture_s;
  logic [WIDTH-1:0]    ovf_set_s;
  logic                found_s;
  logic                load_s;
  logic                grant_s;
  logic [IDX_W-1:0]    pick_s;
  logic [IDX_W-1:0]    cand_s;

  // Edge qualification: line differs from its filtered level for the last filter sample
  always_comb begin
    qual_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      qual_s[i] = (in_line[i] != filt_line[i]) && (cnt_r[i] == CNT_LAST);
    end
  end

  // Round-robin scan: walk offsets from far to near so the nearest set bit after last_grant wins
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      cand_s  = IDX_W'((int'(last_grant_r) + 1 + k) % WIDTH);
      found_s = found_s | pending_r[cand_s];
      pick_s  = pending_r[cand_s] ? cand_s : pick_s;
    end
  end

  // Output-port handshake, grant decode and capture/overflow decisions
  always_comb begin
    load_s      = !out_valid || out_ready;
    grant_s     = load_s && found_s;
    grant_vec_s = '0;
    capture_s   = '0;
    ovf_set_s   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      grant_vec_s[i] = grant_s && (pick_s == IDX_W'(i));
      // A slot being drained this cycle can accept the new event without loss
      capture_s[i]   = qual_s[i] && enable && (!pending_r[i] || grant_vec_s[i]);
      ovf_set_s[i]   = qual_s[i] && enable && pending_r[i] && !grant_vec_s[i];
    end
  end

  // Free-running timestamp counter
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      ts_r <= '0;
    end else begin
      ts_r <= ts_r + TS_WIDTH'(1);
    end
  end

  // Per-line glitch filter counters and filtered levels
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      filt_line <= RESET_LEVEL;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_line[i] == filt_line[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          filt_line[i] <= in_line[i];
          cnt_r[i]     <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // Pending slots: capture takes priority over the grant clear of the same slot
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      pending_r    <= '0;
      pend_level_r <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        pend_ts_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (capture_s[i]) begin
          pending_r[i]    <= 1'b1;
          pend_level_r[i] <= in_line[i];
          pend_ts_r[i]    <= ts_r;
        end else if (grant_vec_s[i]) begin
          pending_r[i] <= 1'b0;
        end else begin
          pending_r[i] <= pending_r[i];
        end
      end
    end
  end

  // Sticky overflow flags: a new overflow in the clearing cycle survives the clear
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow <= '0;
    end else begin
      overflow <= (clr_overflow ? {WIDTH{1'b0}} : overflow) | ovf_set_s;
    end
  end

  // Output event register and round-robin pointer
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid     <= 1'b0;
      out_index     <= '0;
      out_level     <= 1'b0;
      out_timestamp <= '0;
      last_grant_r  <= IDX_LAST;
    end else if (load_s) begin
      if (found_s) begin
        out_valid     <= 1'b1;
        out_index     <= pick_s;
        out_level     <= pend_level_r[pick_s];
        out_timestamp <= pend_ts_r[pick_s];
        last_grant_r  <= pick_s;
      end else begin
        out_valid <= 1'b0;
      end
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: doc/line_event_arbiter.md
# line_event_arbiter

Turns the synchronized line bus into an ordered stream of timestamped edge events. It sits directly behind the input synchronizer and in front of the sniffing/forwarding logic. Each line gets a glitch filter and a one-deep pending slot. A round-robin arbiter then shares a single valid/ready event port among all lines, so downstream logic sees each qualified edge exactly once or sees an overflow flag.

## Interface
- WIDTH, 4: number of lines.
- FILTER_LEN, 3: consecutive differing samples required to accept a level change (≥1).
- TS_WIDTH, 16: timestamp width.
- RESET_LEVEL, {WIDTH{1'b1}}: filtered level of each line after reset (idle-high buses).
- IDX_W, max(1, clog2(WIDTH)): derived width of out_index.

- sys_clk  in  1  system clock, all logic on rising edge.
- n_rst  in  1  reset, asynchronous assert, active-low.
- in_line  in  WIDTH  already-synchronized line levels.
- enable  in  1  1 = capture new events; 0 = filters track, no new pending events.
- clr_overflow  in  1  single-cycle pulse, clears all overflow bits.
- filt_line  out  WIDTH  filtered line levels.
- out_valid  out  1  event available.
- out_ready  in  1  consumer accepts event when out_valid & out_ready.
- out_index  out  IDX_W  line that produced the event.
- out_level  out  1  new filtered level (1 = rising, 0 = falling).
- out_timestamp  out  TS_WIDTH  timestamp of the qualifying edge.
- overflow  out  WIDTH  sticky per-line flag: an event was dropped.

## Operation
- Timestamp counter ts: free-running, +1 every cycle, wraps 2^TS_WIDTH-1 → 0.
- Each line has a filter counter cnt[i]:
  - If in_line[i]==filt_line[i], cnt[i]<=0.
  - Else if cnt[i]==FILTER_LEN-1: the edge qualifies. filt_line[i]<=in_line[i], cnt[i]<=0.
  - Else cnt[i]<=cnt[i]+1.
  - Pulses shorter than FILTER_LEN cycles are ignored. With FILTER_LEN=1, every change qualifies on its first sample.
- Event capture happens on a qualified edge with enable=1. It writes pending[i]=1, pend_level[i]=new level and pend_ts[i]=current ts.
  - If pending[i] is already set and not granted in the same cycle, the new event is dropped, the old event is kept, and overflow[i]<=1.
  - If pending[i] is being granted in the same cycle, the new event loads with no overflow.
- Output register: loads when !out_valid or (out_valid & out_ready).
  - The arbiter picks the first set registered pending bit, scanning from last_grant+1 upward with wrap.
  - It loads out_index, out_level and out_timestamp, sets out_valid=1, clears that pending bit and sets last_grant=index.
  - If nothing is pending, out_valid<=0.
- Outputs are held stable while out_valid & !out_ready.
- enable=0 does not clear pending events. They still drain.
- clr_overflow clears all bits. An overflow set in the same cycle wins.
- Arbiter states are implicit: IDLE (out_valid=0) and HOLD (out_valid=1, waiting for ready).
  - Back-to-back transfers at one event per cycle are supported when out_ready is held at 1.

## Timing
- Reset values:
  - out_valid=0, out_index=0, out_level=0, out_timestamp=0.
  - overflow=0, ts=0, cnt=0, pending=0.
  - filt_line=RESET_LEVEL.
  - last_grant=WIDTH-1, so the first grant scan starts at line 0.
- Reset mid-operation discards pending and in-flight events immediately (asynchronous). No event is generated for lines that differ from RESET_LEVEL until they have been filtered normally.
- Latency, with a level change first sampled at edge e0 and held:
  - filt_line and pending update at edge e0+FILTER_LEN-1.
  - out_valid rises at edge e0+FILTER_LEN if the port is free.
- Captured timestamp equals the ts register value in the cycle before the qualifying edge. That is the value sampled at edge e0+FILTER_LEN-1.
- A pending bit set at edge k is eligible for grant at edge k+1 at the earliest.
- Timestamp wrap is not flagged. The consumer handles modulo arithmetic.

## Test plan
- Single edge, WIDTH=4, FILTER_LEN=3: reset, hold ts count.
  - Stimulus: in_line[2] 1→0 first sampled at edge 10, held.
  - Required: filt_line[2]=0 after edge 12; out_valid=1 after edge 13 with index=2, level=0, timestamp=12.
- Glitch rejection: a 2-cycle low pulse on line 1 with FILTER_LEN=3.
  - Required: no event, filt_line unchanged, cnt returns to 0.
- Round-robin fairness: lines 0, 1 and 3 qualify in the same cycle, out_ready=1.
  - Required: indices 0, 1, 3 on consecutive cycles.
  - Then after last_grant=3, lines 0 and 3 qualify together. Required order: 0, then 3.
- Backpressure and overflow: out_ready=0 with an event from line 0 held in the output.
  - Stimulus: line 0 toggles twice more, the first filling pending and the second overflowing.
  - Required: overflow[0]=1; after ready, the second event (not the third) is delivered.
  - Required: a clr_overflow pulse clears overflow[0].
- Simultaneous grant and capture: line 2 pending is granted in the same cycle its next edge qualifies.
  - Required: both events delivered and overflow[2]=0.
  - Also check that enable=0 still drains pending events but captures no new ones.
- Async reset mid-stream: assert n_rst low while out_valid=1 and pending≠0, off clock edge.
  - Required: out_valid=0 and pending cleared immediately; filt_line=RESET_LEVEL.
